// File: rtl/norm_shift_128_pkg.sv
// Shared widths and the stage payload for the 128-bit normalization shifter.
// NORM_SHIFT_RIGHT_EN adds a direction bit and a sticky bit to the payload.
package norm_shift_128_pkg;

    localparam int EXP_W_DEF = 10;
    localparam int CNT_W     = 7;
    localparam int DATA_W    = 128;
    localparam int EXP_MAX_W = 32;
    localparam int SH_W      = 8;

    // exp is carried at a fixed maximum width; the top uses the low EXP_W bits.
    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [3:0]           cnt_lo;
        logic [EXP_MAX_W-1:0] exp;
        logic                 nz;
        logic                 uf;
`ifdef NORM_SHIFT_RIGHT_EN
        logic                 dir;
        logic                 sticky;
`endif
    } payload_t;

endpackage

// File: rtl/norm_shift_128_stage.sv
// One valid/ready pipeline stage that shifts the payload by i_sel*GRAN bits.
// With NORM_SHIFT_RIGHT_EN, dir=1 shifts right and accumulates the sticky bit.
module norm_shift_stage
    import norm_shift_128_pkg::*;
#(
    parameter int GRAN  = 16,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [SEL_W-1:0] i_sel,
    input  payload_t         i_pld,
    output logic             o_valid,
    input  logic             i_ready,
    output payload_t         o_pld
);

    logic            r_valid;
    payload_t        r_pld;
    logic [SH_W-1:0] w_sh;
    payload_t        w_next;

    assign w_sh = SH_W'(i_sel) * SH_W'(GRAN);

`ifdef NORM_SHIFT_RIGHT_EN
    logic [DATA_W-1:0] w_lost_bits;
    // Bits that fall off the LSB end on a right shift, moved up to the MSBs.
    assign w_lost_bits = (w_sh == '0) ? '0 : (i_pld.data << (SH_W'(DATA_W) - w_sh));
`endif

    always_comb begin
        w_next = i_pld;
`ifdef NORM_SHIFT_RIGHT_EN
        if (i_pld.dir) begin
            w_next.data   = i_pld.data >> w_sh;
            w_next.sticky = i_pld.sticky | (|w_lost_bits);
        end else begin
            w_next.data = i_pld.data << w_sh;
        end
`else
        w_next.data = i_pld.data << w_sh;
`endif
    end

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_pld   = r_pld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pld   <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_pld <= w_next;
            end
        end
    end

endmodule

// File: rtl/norm_shift_128.sv
// Two-stage 128-bit normalization shifter: coarse 16-bit step then fine 1-bit step.
// Optional NORM_SHIFT_RIGHT_EN adds in_dir/out_sticky for right (denormalizing) shifts.
module norm_shift_128
    import norm_shift_128_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CNT_W-1:0]  in_cnt,
    input  logic              in_nz,
    input  logic [EXP_W-1:0]  in_exp,
`ifdef NORM_SHIFT_RIGHT_EN
    input  logic              in_dir,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_uf,
`ifdef NORM_SHIFT_RIGHT_EN
    output logic              out_sticky,
`endif
    output logic              out_zero
);

    localparam int XW = EXP_W + 1;

    logic [XW-1:0]    w_exp_x;
    logic [XW-1:0]    w_cnt_x;
    logic [XW-1:0]    w_diff;
    logic [EXP_W-1:0] w_exp_res;
    logic             w_uf;
    payload_t         w_s1_in;
    payload_t         w_s1_out;
    payload_t         w_s2_out;
    logic             w_s1_valid;
    logic             w_s2_valid;
    logic             w_s2_ready;
    logic             w_unused;

    assign w_exp_x = {1'b0, in_exp};
    assign w_cnt_x = XW'(in_cnt);
    assign w_diff  = w_exp_x - w_cnt_x;

`ifdef NORM_SHIFT_RIGHT_EN
    logic [XW-1:0] w_sum;
    assign w_sum = w_exp_x + w_cnt_x;
`endif

    // Exponent adjust resolved up front so stage 2 only carries the result.
    always_comb begin
        w_uf      = w_diff[EXP_W];
        w_exp_res = w_uf ? '0 : w_diff[EXP_W-1:0];
`ifdef NORM_SHIFT_RIGHT_EN
        if (in_dir) begin
            w_uf      = w_sum[EXP_W];
            w_exp_res = w_uf ? '1 : w_sum[EXP_W-1:0];
        end
`endif
        if (!in_nz) begin
            w_uf      = 1'b0;
            w_exp_res = '0;
        end
    end

    always_comb begin
        w_s1_in        = '0;
        w_s1_in.data   = in_nz ? in_data : '0;
        w_s1_in.cnt_lo = in_cnt[3:0];
        w_s1_in.exp    = EXP_MAX_W'(w_exp_res);
        w_s1_in.nz     = in_nz;
        w_s1_in.uf     = w_uf;
`ifdef NORM_SHIFT_RIGHT_EN
        w_s1_in.dir    = in_dir;
        w_s1_in.sticky = 1'b0;
`endif
    end

    norm_shift_stage #(
        .GRAN  (16),
        .SEL_W (3)
    ) u_stage_coarse (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_sel   (in_cnt[6:4]),
        .i_pld   (w_s1_in),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_pld   (w_s1_out)
    );

    norm_shift_stage #(
        .GRAN  (1),
        .SEL_W (4)
    ) u_stage_fine (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_sel   (w_s1_out.cnt_lo),
        .i_pld   (w_s1_out),
        .o_valid (w_s2_valid),
        .i_ready (out_ready),
        .o_pld   (w_s2_out)
    );

    assign out_valid = w_s2_valid;
    assign out_data  = w_s2_out.data;
    assign out_exp   = w_s2_out.exp[EXP_W-1:0];
    assign out_uf    = w_s2_out.uf;
    // Gated by valid so the cleared payload (nz=0) does not read as a zero result.
    assign out_zero  = w_s2_valid & ~w_s2_out.nz;
`ifdef NORM_SHIFT_RIGHT_EN
    assign out_sticky = w_s2_out.sticky;
`endif

    assign w_unused = &{1'b0, w_s2_out.cnt_lo, w_s2_out.exp};

endmodule

// File: tb/tb_norm_shift_128.sv
// Directed, table-driven bench for norm_shift_128 plus stall and reset sequences.
// Builds with or without NORM_SHIFT_RIGHT_EN.
module tb_norm_shift_128;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [6:0]   in_cnt;
    logic         in_nz;
    logic [9:0]   in_exp;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [9:0]   out_exp;
    logic         out_uf;
    logic         out_zero;
`ifdef NORM_SHIFT_RIGHT_EN
    logic         in_dir;
    logic         out_sticky;
    logic         tb_xs;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    norm_shift_128 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_nz     (in_nz),
        .in_exp    (in_exp),
`ifdef NORM_SHIFT_RIGHT_EN
        .in_dir    (in_dir),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_exp   (out_exp),
        .out_uf    (out_uf),
`ifdef NORM_SHIFT_RIGHT_EN
        .out_sticky(out_sticky),
`endif
        .out_zero  (out_zero)
    );

    typedef struct {
        logic [127:0] d;
        logic [6:0]   c;
        logic         nz;
        logic [9:0]   e;
        logic [127:0] xd;
        logic [9:0]   xe;
        logic         xuf;
        logic         xz;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // One isolated operand: checks 2-cycle latency and every output field.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = v.d;
        in_cnt    = v.c;
        in_nz     = v.nz;
        in_exp    = v.e;
        out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk({tag, "_lat1_valid"}, out_valid, 0);
        @(negedge clk);
        #1;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"},  out_data,  v.xd);
        chk({tag, "_exp"},   out_exp,   v.xe);
        chk({tag, "_uf"},    out_uf,    v.xuf);
        chk({tag, "_zero"},  out_zero,  v.xz);
`ifdef NORM_SHIFT_RIGHT_EN
        chk({tag, "_sticky"}, out_sticky, tb_xs);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int tx;
        int rx;
        int stalls;
        int seen;
        logic [127:0] one;

        one = 128'd1;
        vecs[0] = '{one << 100, 7'd27, 1'b1, 10'd200, one << 127, 10'd173, 1'b0, 1'b0};
        vecs[1] = '{one, 7'd127, 1'b1, 10'd50, one << 127, 10'd0, 1'b1, 1'b0};
        vecs[2] = '{128'd0, 7'h55, 1'b0, 10'd9, 128'd0, 10'd0, 1'b0, 1'b1};
        vecs[3] = '{128'hFFFF, 7'd112, 1'b1, 10'd112, 128'hFFFF << 112, 10'd0, 1'b0, 1'b0};
        vecs[4] = '{one << 127, 7'd0, 1'b1, 10'd5, one << 127, 10'd5, 1'b0, 1'b0};
        vecs[5] = '{128'h000000F0_00000000_00000000_00000001, 7'd24, 1'b1, 10'd1023,
                    128'hF0000000_00000000_00000000_01000000, 10'd999, 1'b0, 1'b0};
        vecs[6] = '{one << 126, 7'd1, 1'b1, 10'd0, one << 127, 10'd0, 1'b1, 1'b0};
        vecs[7] = '{one << 108, 7'd19, 1'b1, 10'd19, one << 127, 10'd0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cnt    = '0;
        in_nz     = 1'b0;
        in_exp    = '0;
        out_ready = 1'b1;
`ifdef NORM_SHIFT_RIGHT_EN
        in_dir = 1'b0;
        tb_xs  = 1'b0;
`endif
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_exp",   out_exp,   0);
        chk("rst_out_uf",    out_uf,    0);
        chk("rst_out_zero",  out_zero,  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        #1 chk("rst_in_ready", in_ready, 1);
        out_ready = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

`ifdef NORM_SHIFT_RIGHT_EN
        in_dir = 1'b1;
        tb_xs = 1'b1;
        run_vec('{128'hFF, 7'd4, 1'b1, 10'd10, 128'hF, 10'd14, 1'b0, 1'b0}, "r0");
        tb_xs = 1'b1;
        run_vec('{128'hFF, 7'd5, 1'b1, 10'd1020, 128'h7, 10'd1023, 1'b1, 1'b0}, "r1");
        tb_xs = 1'b0;
        run_vec('{one << 32, 7'd20, 1'b1, 10'd10, one << 12, 10'd30, 1'b0, 1'b0}, "r2");
        tb_xs = 1'b0;
        run_vec('{128'd0, 7'd3, 1'b0, 10'd5, 128'd0, 10'd0, 1'b0, 1'b1}, "r3");
        @(negedge clk);
        in_dir = 1'b0;
`endif

        // Back-to-back stream with out_ready dropped for cycles 3..6.
        tx = 0;
        rx = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 100 && rx < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (tx < 8) begin
                in_valid = 1'b1;
                in_data  = 128'(tx + 1) << 10;
                in_cnt   = 7'(9 * tx);
                in_nz    = 1'b1;
                in_exp   = 10'd200;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && !in_ready) stalls++;
            if (out_valid && out_ready) begin
                chk($sformatf("stream%0d_data", rx), out_data, (128'(rx + 1) << 10) << (9 * rx));
                chk($sformatf("stream%0d_exp", rx), out_exp, 10'(200 - 9 * rx));
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        chk("stream_rx_count", rx, 8);
        chk("stream_stall_cycles", stalls, 4);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("stream_drained", out_valid, 0);

        // Fill the pipeline with out_ready low, then reset mid-flight.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = vecs[1].d;
            in_cnt   = vecs[1].c;
            in_nz    = 1'b1;
            in_exp   = vecs[1].e;
        end
        #1;
        chk("full_out_valid", out_valid, 1);
        chk("full_out_uf", out_uf, 1);
        chk("full_in_ready", in_ready, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_out_data", out_data, 0);
        chk("async_out_uf", out_uf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1 chk("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("no_stale_result", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
